uart_rx_ovs: RTL
================

Name: uart_rx_ovs

Overview:
- Parametrised successor to the single-mode UART receiver.
- Receives asynchronous serial frames using an oversampled bit clock and 3-sample majority voting.
- Supports runtime-selectable data length, parity and stop bits.
- Pushes each received word plus its per-frame error flags into an internal FIFO read by the bus-side logic. Sits between the pad synchroniser-free RX pin and the peripheral register block.

Parameters:
- DATA_WIDTH, 8, maximum data bits per frame; legal 5..9.
- FIFO_DEPTH, 16, FIFO entries; power of two, >=2.
- OVS, 16, sample ticks per bit; even, >=8.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- baud_div_i  in  16  clocks per sample tick; 0 treated as 1
- data_len_i  in  4  data bits per frame, 5..DATA_WIDTH; out-of-range values clamp to DATA_WIDTH
- parity_i  in  2  00 none, 01 even, 10 odd, 11 none
- stop2_i  in  1  1 = two stop bits checked
- rx_en_i  in  1  receiver enable
- rx_bit_i  in  1  serial input, asynchronous
- rx_re_i  in  1  FIFO pop request
- err_clr_i  in  1  clears the sticky overrun flag
- dout_o  out  DATA_WIDTH  popped data, zero-extended above data_len
- frame_err_o  out  1  stop-bit error of the popped entry
- parity_err_o  out  1  parity error of the popped entry
- full_o  out  1  FIFO full
- empty_o  out  1  FIFO empty
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overrun_o  out  1  sticky: a frame was dropped because the FIFO was full

Behaviour:
- Reset values:
  - dout_o, frame_err_o, parity_err_o, overrun_o, count_o, full_o = 0; empty_o = 1.
  - FSM in IDLE; synchroniser flops = 1.
- Synchroniser and tick:
  - rx_bit_i passes through a 2-flop synchroniser.
  - Tick counter reloads at baud_div_i-1 and emits a 1-clock tick on reaching 0.
  - The counter runs only while rx_en_i = 1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH.
  - IDLE: on a synchronised 1->0 edge, reset the sample counter and latch data_len_i, parity_i and stop2_i for the whole frame; go to START.
  - START: at sample OVS/2, majority of samples OVS/2-1..OVS/2+1 must be 0, otherwise it is a false start and the FSM returns to IDLE. At sample OVS-1 go to DATA.
  - DATA: each bit is the majority vote of samples OVS/2-1, OVS/2, OVS/2+1, shifted in LSB first. After data_len bits go to PARITY if parity is enabled, else STOP1.
  - PARITY: voted bit compared with XOR of data (even) or its inverse (odd); mismatch sets the parity error.
  - STOP1: voted bit = 0 sets the frame error. If stop2 go to STOP2, else PUSH. The frame error check occurs at mid-bit; the FSM leaves STOP1 at sample OVS/2+1, not the full bit, so back-to-back frames resync.
  - STOP2: same check as STOP1, then PUSH.
  - PUSH: one clock. Write {parity error, frame error, data} into the FIFO, return to IDLE.
- FIFO:
  - Push when not full, or when full with a simultaneous pop (net count unchanged).
  - Push when full without a pop: the frame is dropped and overrun_o is set.
  - overrun_o clears only on err_clr_i. If err_clr_i and a new overrun occur in the same cycle, set wins.
- Read:
  - rx_re_i with empty_o = 0 pops the head.
  - dout_o, frame_err_o and parity_err_o register the head entry on that edge and hold until the next pop.
  - rx_re_i while empty is ignored and outputs hold.
- Pointers wrap modulo FIFO_DEPTH; count_o is exact, 0..FIFO_DEPTH.
- rx_en_i = 0 mid-frame: FSM returns to IDLE on the next clock and the partial frame is discarded. FIFO contents and flags are preserved.
- Configuration inputs changing mid-frame have no effect until the next start bit.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- When defined:
  - Adds output port break_o (1 bit, reset 0).
  - A frame with all data bits 0, the parity bit 0 (if enabled) and stop bit 0 is a break.
  - On a break: break_o pulses for 1 clock, nothing is pushed, and the FSM waits for the line to return high before IDLE.
- When undefined:
  - No break_o port.
  - Such a frame is pushed with frame_err set and the FSM returns to IDLE immediately.

Test Plan:
- Setup: OVS = 16, baud_div_i = 4, so 64 clocks per bit.
- 8N1: send 'h41, 'h42, 'h43, 'h0A -> count_o = 4; four pops return the same data in order with both error flags 0; empty_o = 1 afterwards.
- 7E2 (data_len_i = 7, parity_i = 01, stop2_i = 1): send 'h35 with correct parity, then 'h35 with the parity bit inverted -> parity_err_o = 0 for the first entry, 1 for the second.
- Stop bit driven 0 on 'hA5 -> popped entry has data 'hA5 and frame_err_o = 1; the next valid frame 'h5A is received cleanly.
- Glitch: rx_bit_i low for 20 clocks -> no push, FSM back in IDLE, count_o = 0.
- Overrun: send 17 frames with no reads -> full_o = 1, count_o = 16, overrun_o = 1. Pulse err_clr_i -> overrun_o = 0. FIFO holds the first 16 frames.
- Reset: assert rst_i mid-DATA -> all outputs return to reset values asynchronously; the next full frame 'h3C is received correctly.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// uart_rx_ovs -- oversampling UART receiver with receive FIFO
//
// Recovers asynchronous serial frames from rx_bit_i. The line is sampled at
// OVS ticks per bit, and each bit is a 3-sample majority vote around mid-bit.
// Each received word and its error flags are written into a FIFO that the
// bus side drains.
//
// Optional build macro:
//   UART_RX_BREAK_DET_EN  adds break_o. A frame whose data, parity (if used)
//                         and stop bits are all 0 pulses break_o and is not
//                         written to the FIFO.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   baud_div_i     clocks per sample tick (0 behaves as 1)
//   data_len_i     data bits per frame, 5..DATA_WIDTH; other values give
//                  DATA_WIDTH
//   parity_i       00/11 none, 01 even, 10 odd
//   stop2_i        check a second stop bit
//   rx_en_i        receiver enable; low abandons any frame in progress
//   rx_bit_i       asynchronous serial input
//   rx_re_i        FIFO pop request
//   err_clr_i      clears the sticky overrun flag
//   dout_o         popped data, zero-extended above the frame length
//   frame_err_o    stop-bit error of the popped entry
//   parity_err_o   parity error of the popped entry
//   full_o         FIFO full
//   empty_o        FIFO empty
//   count_o        FIFO occupancy, 0..FIFO_DEPTH
//   overrun_o      sticky: a frame was dropped because the FIFO was full
//   break_o        (UART_RX_BREAK_DET_EN only) one-clock break pulse
// ---------------------------------------------------------------------------
module uart_rx_ovs #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVS        = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [15:0]                   baud_div_i,
  input  logic [3:0]                    data_len_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          rx_en_i,
  input  logic                          rx_bit_i,
  input  logic                          rx_re_i,
  input  logic                          err_clr_i,
`ifdef UART_RX_BREAK_DET_EN
  output logic                          break_o,
`endif
  output logic [DATA_WIDTH-1:0]         dout_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(OVS);
  localparam int EW = DATA_WIDTH + 2;

  // The three voting samples straddle mid-bit. The vote is resolved on the
  // tick of the last sample, when all three are available.
  localparam logic [SW-1:0] SAMP_A   = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SAMP_B   = SW'(OVS / 2);
  localparam logic [SW-1:0] SAMP_C   = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] SAMP_END = SW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_PUSH
`ifdef UART_RX_BREAK_DET_EN
    , S_BRK
`endif
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < 4'd5 || len > 4'(DATA_WIDTH))
      return 4'(DATA_WIDTH);
    return len;
  endfunction

  state_t                  state, state_n;
  logic                    sync_p0, sync_p1, prev_p2;
  logic                    fall, start;
  logic [15:0]             tick_cnt;
  logic                    tick;
  logic [SW-1:0]           samp_cnt;
  logic [3:0]              bit_cnt;
  logic [3:0]              len_l;
  logic                    par_en_l, odd_l, stop2_l;
  logic                    perr, ferr;
  logic                    s_a, s_b, vote;
  logic                    vote_tick, end_tick, last_bit;
  logic [DATA_WIDTH-1:0]   data_sh;
`ifdef UART_RX_BREAK_DET_EN
  logic                    par_bit;
  logic                    brk;
`endif

  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count_q;
  logic                    push_req, do_push, pop;

  // ---- stage p0/p1: two-flop synchroniser, p2: previous value for edge ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= rx_bit_i;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign fall  = prev_p2 & ~sync_p1;
  assign start = (state == S_IDLE) && rx_en_i && fall;

  // ---- sample tick generator: frozen while the receiver is disabled ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (rx_en_i) begin
      if (tick_cnt == 16'd0) begin
        tick     <= 1'b1;
        tick_cnt <= (baud_div_i == 16'd0) ? 16'd0 : baud_div_i - 16'd1;
      end else begin
        tick     <= 1'b0;
        tick_cnt <= tick_cnt - 16'd1;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign vote      = maj3(s_a, s_b, sync_p1);
  assign vote_tick = tick && (samp_cnt == SAMP_C);
  assign end_tick  = tick && (samp_cnt == SAMP_END);
  assign last_bit  = (bit_cnt == len_l - 4'd1);
`ifdef UART_RX_BREAK_DET_EN
  assign brk = (data_sh == '0) && (!par_en_l || !par_bit) && !vote;
`endif

  // ---- frame FSM ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!rx_en_i) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (fall) state_n = S_START;
        S_START: begin
          if (vote_tick && vote)  state_n = S_IDLE;   // false start
          else if (end_tick)      state_n = S_DATA;
        end
        S_DATA:   if (end_tick && last_bit) state_n = par_en_l ? S_PARITY : S_STOP1;
        S_PARITY: if (end_tick) state_n = S_STOP1;
        // With one stop bit the FSM leaves at mid-bit so the next start
        // edge is never missed; with two it finishes the bit to stay aligned.
        S_STOP1: begin
`ifdef UART_RX_BREAK_DET_EN
          if (vote_tick && brk)                  state_n = S_BRK;
          else
`endif
          if (vote_tick && !stop2_l)             state_n = S_PUSH;
          else if (end_tick && stop2_l)          state_n = S_STOP2;
        end
        S_STOP2:  if (vote_tick) state_n = S_PUSH;
        S_PUSH:   state_n = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
        S_BRK:    if (sync_p1) state_n = S_IDLE;
`endif
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // ---- frame control: counters, latched configuration, error flags ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      len_l    <= 4'(DATA_WIDTH);
      par_en_l <= 1'b0;
      odd_l    <= 1'b0;
      stop2_l  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (start) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      len_l    <= clamp_len(data_len_i);
      par_en_l <= (parity_i == 2'b01) || (parity_i == 2'b10);
      odd_l    <= (parity_i == 2'b10);
      stop2_l  <= stop2_i;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (state != S_IDLE && tick) begin
      samp_cnt <= (samp_cnt == SAMP_END) ? '0 : samp_cnt + 1'b1;
      if (state == S_DATA && samp_cnt == SAMP_END)
        bit_cnt <= bit_cnt + 4'd1;
      if (samp_cnt == SAMP_C) begin
        if (state == S_PARITY)
          perr <= vote ^ (^data_sh) ^ odd_l;
        if ((state == S_STOP1 || state == S_STOP2) && !vote)
          ferr <= 1'b1;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) break_o <= 1'b0;
    else       break_o <= (state == S_STOP1) && (state_n == S_BRK);
  end
`endif

  // ---- frame data: voting samples and shift-in, no reset needed ----
  always_ff @(posedge clk_i) begin
    if (start) begin
      data_sh <= '0;
    end else if (state != S_IDLE && tick) begin
      if (samp_cnt == SAMP_A) s_a <= sync_p1;
      if (samp_cnt == SAMP_B) s_b <= sync_p1;
      if (samp_cnt == SAMP_C) begin
        if (state == S_DATA) begin
          for (int i = 0; i < DATA_WIDTH; i++)
            if (bit_cnt == 4'(i)) data_sh[i] <= vote;
        end
`ifdef UART_RX_BREAK_DET_EN
        if (state == S_PARITY) par_bit <= vote;
`endif
      end
    end
  end

  // ---- receive FIFO ----
  assign push_req = (state == S_PUSH);
  assign pop      = rx_re_i && !empty_o;
  // A full FIFO still accepts a word when a pop frees the head slot.
  assign do_push  = push_req && (!full_o || pop);

  assign full_o  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= {perr, ferr, data_sh};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      overrun_o    <= 1'b0;
      dout_o       <= '0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {parity_err_o, frame_err_o, dout_o} <= mem[rd_ptr];
      end
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A new overrun beats a simultaneous clear.
      if (push_req && full_o && !pop) overrun_o <= 1'b1;
      else if (err_clr_i)             overrun_o <= 1'b0;
    end
  end

endmodule
